// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers: each channel toggles a square
// wave and pulses a one-cycle tick every term+1 enabled clk_in cycles.
module clk_div_bank #(
    parameter int                        NUM_CH    = 3,
    parameter int                        CNT_W     = 27,
    parameter logic [NUM_CH*CNT_W-1:0]   INIT_TERM = {27'd2_999_999, 27'd4_999_999, 27'd100_000}
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         en,
    input  logic                      sync_clr,
    input  logic                      cfg_wr,
    input  logic [2:0]                cfg_ch,
    input  logic [CNT_W-1:0]          cfg_val,
    output logic [NUM_CH-1:0]         divided_clk,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH*CNT_W-1:0]   term_out
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_term;
        logic             r_dclk;
        logic             r_tick;
        logic             w_wr_hit;

        assign w_wr_hit = cfg_wr & (cfg_ch == 3'(i));

        // Terminal value register; a write lands even alongside sync_clr.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                r_term <= INIT_TERM[i*CNT_W +: CNT_W];
            end else if (w_wr_hit) begin
                r_term <= cfg_val;
            end else begin
                r_term <= r_term;
            end
        end

        // Counter, square wave and tick; a rate change restarts the count but keeps the level.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt  <= {CNT_W{1'b0}};
                r_dclk <= 1'b0;
                r_tick <= 1'b0;
            end else if (sync_clr) begin
                r_cnt  <= {CNT_W{1'b0}};
                r_dclk <= 1'b0;
                r_tick <= 1'b0;
            end else if (w_wr_hit) begin
                r_cnt  <= {CNT_W{1'b0}};
                r_tick <= 1'b0;
            end else if (!en[i]) begin
                r_tick <= 1'b0;
            end else if (r_cnt == r_term) begin
                r_cnt  <= {CNT_W{1'b0}};
                r_dclk <= ~r_dclk;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                r_tick <= 1'b0;
            end
        end

        assign divided_clk[i]             = r_dclk;
        assign tick[i]                    = r_tick;
        assign term_out[i*CNT_W +: CNT_W] = r_term;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank using shortened reset terms so every phase
// relationship can be observed within a few hundred cycles.
module tb_clk_div_bank;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 27;
    localparam logic [NUM_CH*CNT_W-1:0] TB_INIT = {27'd14, 27'd19, 27'd9};

    logic                    clk_in   = 1'b0;
    logic                    rst_n    = 1'b1;
    logic [NUM_CH-1:0]       en       = 3'b000;
    logic                    sync_clr = 1'b0;
    logic                    cfg_wr   = 1'b0;
    logic [2:0]              cfg_ch   = 3'd0;
    logic [CNT_W-1:0]        cfg_val  = 27'd0;
    logic [NUM_CH-1:0]       divided_clk;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH*CNT_W-1:0] term_out;

    clk_div_bank #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .INIT_TERM(TB_INIT)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .en         (en),
        .sync_clr   (sync_clr),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_val    (cfg_val),
        .divided_clk(divided_clk),
        .tick       (tick),
        .term_out   (term_out)
    );

    always #5 clk_in = ~clk_in;

    int     n_vec = 0;
    int     n_err = 0;
    longint m = 0;
    longint r_ref [NUM_CH];
    longint p_per [NUM_CH];
    bit     l_lvl [NUM_CH];
    bit     held;
    logic [NUM_CH*CNT_W-1:0] snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic bit exp_tick(input int i);
        return (m > r_ref[i]) && (((m - r_ref[i]) % p_per[i]) == 0);
    endfunction

    function automatic bit exp_dclk(input int i);
        return l_lvl[i] ^ ((((m - r_ref[i]) / p_per[i]) % 2) == 1);
    endfunction

    task automatic step();
        @(posedge clk_in);
        m++;
        @(negedge clk_in);
    endtask

    task automatic check_cycle(input logic [2:0] mask);
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) begin
                chk($sformatf("tick%0d@%0d", i, m), tick[i], exp_tick(i));
                chk($sformatf("dclk%0d@%0d", i, m), divided_clk[i], exp_dclk(i));
            end
        end
    endtask

    task automatic run(input int n, input logic [2:0] mask);
        for (int k = 0; k < n; k++) begin
            step();
            check_cycle(mask);
        end
    endtask

    task automatic do_write(input int ch, input logic [CNT_W-1:0] val, input bit clr);
        cfg_wr   = 1'b1;
        cfg_ch   = 3'(ch);
        cfg_val  = val;
        sync_clr = clr;
        if (ch < NUM_CH) begin
            l_lvl[ch] = exp_dclk(ch);
            r_ref[ch] = m + 1;
            p_per[ch] = longint'(val) + 1;
        end
        if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                l_lvl[i] = 1'b0;
                r_ref[i] = m + 1;
            end
        end
        step();
        cfg_wr   = 1'b0;
        sync_clr = 1'b0;
        check_cycle(3'b111);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("rst_dclk", divided_clk, 3'b000);
        chk("rst_tick", tick, 3'b000);
        chk("rst_term", term_out, TB_INIT);

        // Release with all channels enabled; first tick/toggle at term+1 edges.
        rst_n = 1'b1;
        en    = 3'b111;
        for (int i = 0; i < NUM_CH; i++) begin
            r_ref[i] = 0;
            l_lvl[i] = 1'b0;
            p_per[i] = longint'(TB_INIT[i*CNT_W +: CNT_W]) + 1;
        end
        run(60, 3'b111);

        // Rate change on ch1; the others keep their phase.
        chk("term1_pre", term_out[CNT_W +: CNT_W], 27'd19);
        do_write(1, 27'd3, 1'b0);
        chk("term1_post", term_out[CNT_W +: CNT_W], 27'd3);
        chk("term0_kept", term_out[0 +: CNT_W], 27'd9);
        run(40, 3'b111);

        // Freeze ch1 after two counts for five cycles.
        for (int k = 0; k < 4 && ((m - r_ref[1]) % p_per[1]) != 2; k++) begin
            step();
            check_cycle(3'b111);
        end
        en[1] = 1'b0;
        held  = exp_dclk(1);
        for (int k = 0; k < 5; k++) begin
            step();
            check_cycle(3'b101);
            chk($sformatf("frz_tick1@%0d", m), tick[1], 1'b0);
            chk($sformatf("frz_dclk1@%0d", m), divided_clk[1], held);
        end
        en[1]    = 1'b1;
        r_ref[1] = r_ref[1] + 5;
        run(12, 3'b111);

        // ch2 at term 0, then reprogram while its level is high.
        do_write(2, 27'd0, 1'b0);
        run(6, 3'b111);
        for (int k = 0; k < 3 && !exp_dclk(2); k++) begin
            step();
            check_cycle(3'b111);
        end
        chk("dclk2_high_before_wr", divided_clk[2], 1'b1);
        do_write(2, 27'd5, 1'b0);
        run(14, 3'b111);

        // sync_clr together with a ch0 write.
        do_write(0, 27'd7, 1'b1);
        chk("clr_term0", term_out[0 +: CNT_W], 27'd7);
        chk("clr_term2", term_out[2*CNT_W +: CNT_W], 27'd5);
        run(20, 3'b111);

        // Out-of-range channel index is ignored.
        snap = term_out;
        do_write(5, 27'd123, 1'b0);
        chk("bad_ch_term", term_out, snap);
        run(5, 3'b111);

        // Maximum terminal value: no tick within a short window.
        do_write(1, {CNT_W{1'b1}}, 1'b0);
        chk("term1_ones", term_out[CNT_W +: CNT_W], {CNT_W{1'b1}});
        run(20, 3'b111);

        // Asynchronous reset between edges while ch0 is high.
        for (int k = 0; k < 16 && !exp_dclk(0); k++) begin
            step();
            check_cycle(3'b111);
        end
        chk("dclk0_high_before_rst", divided_clk[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dclk", divided_clk, 3'b000);
        chk("arst_tick", tick, 3'b000);
        chk("arst_term", term_out, TB_INIT);
        repeat (2) @(negedge clk_in);
        chk("arst_hold_dclk", divided_clk, 3'b000);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            r_ref[i] = m;
            l_lvl[i] = 1'b0;
            p_per[i] = longint'(TB_INIT[i*CNT_W +: CNT_W]) + 1;
        end
        run(25, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
